stage_sink_sync: RTL

- Clocked tail stage of the asynchronous pipeline. Consumes the 4-phase bundled-data handshake (req/ack/data) produced by the last self-timed stage.
- Synchronises req into the clk domain and captures each token into a small FIFO. Acknowledges upstream and presents tokens on a valid/ready stream to synchronous logic.
- Applies backpressure by withholding ack while the FIFO is full.

---
 rtl/stage_sink_sync.sv | 138 +++++++++++++
 1 files changed

// File: rtl/stage_sink_sync.sv
// -----------------------------------------------------------------------------
// stage_sink_sync
// Clocked tail stage of the self-timed pipeline. Brings the 4-phase
// bundled-data request into the clk domain, captures one token per request
// phase into a small show-ahead FIFO, acknowledges upstream, and presents the
// buffered tokens as a valid/ready stream. While the FIFO is full the
// acknowledge is withheld, which stalls the asynchronous pipeline behind us.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   rst       - synchronous active-high reset
//   req_in    - 4-phase request from upstream (asynchronous to clk)
//   data_in   - bundled data, stable while req_in is high
//   ack_out   - 4-phase acknowledge to upstream (registered)
//   out_valid - FIFO holds at least one token
//   out_data  - head-of-FIFO token, meaningful only while out_valid is high
//   out_ready - downstream takes the head token when out_valid & out_ready
//   count     - current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module stage_sink_sync #(
  parameter int DW    = 3,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_in,
  input  logic [DW-1:0] data_in,
  output logic          ack_out,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    ACKED
  } state_t;

  state_t        r_state;
  logic          r_ack;
  logic          r_reqS1;
  logic          r_reqS;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  // The full test uses the occupancy from before this edge, so a pop while
  // full only frees the slot for the following edge's capture.
  assign w_full = (r_count == FULL_COUNT);
  assign w_push = (r_state == IDLE) && r_reqS && !w_full;
  assign w_pop  = (r_count != '0) && out_ready;

  // Two-flop synchroniser on the request. data_in is not synchronised: the
  // two-cycle delay through these flops is what lets the bundled data settle
  // before it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reqS1 <= 1'b0;
      r_reqS  <= 1'b0;
    end else begin
      r_reqS1 <= req_in;
      r_reqS  <= r_reqS1;
    end
  end

  // Handshake FSM. Capturing only on the IDLE->ACKED transition guarantees a
  // single write per request phase; a new token needs req seen low first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state <= ACKED;
            r_ack   <= 1'b1;
          end
        end
        ACKED: begin
          if (!r_reqS) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ack_out   = r_ack;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rdPtr];
  assign count     = r_count;

endmodule
